// File: rtl/interrupt_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: state encoding,
// mcause interrupt codes and the fixed arbitration order.
package interrupt_arbiter_pkg;

  localparam int ECODE_W = 4;
  localparam int NUM_IRQ = 6;

  typedef logic [31:0] mip_t;
  typedef logic [31:0] mie_t;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } privilege_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    COOLDOWN = 2'd2
  } irq_arb_state_t;

  localparam logic [ECODE_W-1:0] IRQ_M_EXT   = 4'd11;
  localparam logic [ECODE_W-1:0] IRQ_S_EXT   = 4'd9;
  localparam logic [ECODE_W-1:0] IRQ_M_TIMER = 4'd7;
  localparam logic [ECODE_W-1:0] IRQ_S_TIMER = 4'd5;
  localparam logic [ECODE_W-1:0] IRQ_M_SOFT  = 4'd3;
  localparam logic [ECODE_W-1:0] IRQ_S_SOFT  = 4'd1;

  // Highest priority first; applied once for M-targets, then for S-targets.
  localparam logic [ECODE_W-1:0] IRQ_PRIO [NUM_IRQ] = '{
    IRQ_M_EXT, IRQ_M_SOFT, IRQ_M_TIMER, IRQ_S_EXT, IRQ_S_SOFT, IRQ_S_TIMER
  };

endpackage

// File: rtl/interrupt_arbiter_irq_synchronizer.sv
// Single-bit multi-flop synchronizer for asynchronous interrupt pins,
// cleared by the synchronous active-low reset.
module irq_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: builds the mip view, masks and routes each source to M or S,
// picks one winner and presents it to trap entry with a stable req/ack handshake.
//
// state    | meaning
// IDLE     | no request presented; latch the next eligible winner
// REQUEST  | irq_req high, code/target held until ack or withdrawal
// COOLDOWN | one idle cycle after ack so trap-entry CSR updates settle
module interrupt_arbiter
  import interrupt_arbiter_pkg::*;
#(
  parameter int S_MODE      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_ext_irq,
  input  logic               s_ext_irq,
  input  logic               m_timer_irq,
  input  logic               m_soft_irq,
  input  logic               sw_ssip,
  input  logic               sw_stip,
  input  logic [31:0]        mie,
  input  logic [31:0]        mideleg,
  input  logic               mstatus_mie,
  input  logic               mstatus_sie,
  input  logic [1:0]         privilege,
  input  logic               irq_block,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [ECODE_W-1:0] irq_code,
  output logic               irq_to_s,
  output logic [31:0]        mip
);

  logic m_ext_sync;
  logic s_ext_sync;

  irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_m_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (m_ext_irq),
    .q_o   (m_ext_sync)
  );

  irq_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_s_ext (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (s_ext_irq),
    .q_o   (s_ext_sync)
  );

  mip_t        mip_view;
  logic [31:0] deleg;
  logic [31:0] active;
  logic        m_elig;
  logic        s_elig;

  always_comb begin
    mip_view              = '0;
    mip_view[IRQ_M_EXT]   = m_ext_sync;
    mip_view[IRQ_M_TIMER] = m_timer_irq;
    mip_view[IRQ_M_SOFT]  = m_soft_irq;
    if (S_MODE != 0) begin
      mip_view[IRQ_S_EXT]   = s_ext_sync;
      mip_view[IRQ_S_TIMER] = sw_stip;
      mip_view[IRQ_S_SOFT]  = sw_ssip;
    end
  end

  assign mip    = mip_view;
  assign deleg  = (S_MODE != 0) ? mideleg : '0;
  assign m_elig = (privilege != PRIV_M) || mstatus_mie;
  assign s_elig = (privilege == PRIV_U) || ((privilege == PRIV_S) && mstatus_sie);
  // Pending, enabled and deliverable to its target at the current privilege.
  assign active = mip_view & mie &
                  ((deleg & {32{s_elig}}) | (~deleg & {32{m_elig}}));

  logic               win_found;
  logic [ECODE_W-1:0] win_code;
  logic               win_to_s;

  always_comb begin
    win_found = 1'b0;
    win_code  = '0;
    win_to_s  = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!win_found && active[IRQ_PRIO[k]] && !deleg[IRQ_PRIO[k]]) begin
        win_found = 1'b1;
        win_code  = IRQ_PRIO[k];
      end
    end
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!win_found && active[IRQ_PRIO[k]] && deleg[IRQ_PRIO[k]]) begin
        win_found = 1'b1;
        win_code  = IRQ_PRIO[k];
        win_to_s  = 1'b1;
      end
    end
  end

  irq_arb_state_t     state_q, state_d;
  logic [ECODE_W-1:0] code_q, code_d;
  logic               to_s_q, to_s_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    to_s_d  = to_s_q;
    case (state_q)
      IDLE: begin
        if (win_found && !irq_block) begin
          state_d = REQUEST;
          code_d  = win_code;
          to_s_d  = win_to_s;
        end
      end
      REQUEST: begin
        if (irq_ack) begin
          state_d = COOLDOWN;
        end else if (!active[code_q] || irq_block) begin
          state_d = IDLE;
        end
      end
      COOLDOWN: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      to_s_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      to_s_q  <= to_s_d;
    end
  end

  assign irq_req  = (state_q == REQUEST);
  assign irq_code = code_q;
  assign irq_to_s = to_s_q;

endmodule
